// File: rtl/popcount_window_accumulator_if.sv
// Stream bundle around the popcount window accumulator: sample input, result output and clear.
// Optional out_max member is present only when POPACC_MAX_TRACK_EN is defined.
interface popcount_window_accumulator_if #(
  parameter int SUM_W = 9
);
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_count;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic             out_above;
  logic             out_err;
`ifdef POPACC_MAX_TRACK_EN
  logic [5:0]       out_max;
`endif

  modport slave (
    input  clear, in_valid, in_count, out_ready,
`ifdef POPACC_MAX_TRACK_EN
    output out_max,
`endif
    output in_ready, out_valid, out_sum, out_above, out_err
  );

  modport master (
    output clear, in_valid, in_count, out_ready,
`ifdef POPACC_MAX_TRACK_EN
    input  out_max,
`endif
    input  in_ready, out_valid, out_sum, out_above, out_err
  );
endinterface

// File: rtl/popcount_window_accumulator.sv
// Sums WINDOW clamped popcount samples and holds the thresholded result on a valid/ready port.
// Define POPACC_MAX_TRACK_EN to add out_max, the largest clamped sample of each window.
module popcount_window_accumulator #(
  parameter int WINDOW = 8,
  parameter int SUM_W  = 9,
  parameter int THRESH = 128
) (
  input  logic clk,
  input  logic rst_n,
  popcount_window_accumulator_if.slave bus
);
  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic [SUM_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;
  logic [SUM_W-1:0] sum_reg, sum_next;
  logic             above_reg, above_next;
  logic             out_err_reg, out_err_next;

  logic             over;
  logic [5:0]       samp;
  logic [SUM_W-1:0] samp_ext;
  logic [SUM_W-1:0] total;
  logic             accept;
  logic             consume;
  logic             last;

  assign over     = bus.in_count > 6'd32;
  assign samp     = over ? 6'd32 : bus.in_count;
  assign samp_ext = SUM_W'(samp);
  assign total    = acc_reg + samp_ext;
  assign last     = (cnt_reg == CNT_W'(WINDOW - 1));

  // In HOLD the input is only open while the consumer drains the result,
  // so an accepted sample never lands on top of an unconsumed one.
  assign bus.in_ready  = (state_reg == ST_ACCUM) ? 1'b1 : bus.out_ready;
  assign bus.out_valid = (state_reg == ST_HOLD);
  assign accept        = bus.in_valid && bus.in_ready;
  assign consume       = bus.out_valid && bus.out_ready;

  assign bus.out_sum   = sum_reg;
  assign bus.out_above = above_reg;
  assign bus.out_err   = out_err_reg;

  // acc/cnt/err are already zero in HOLD, so one accept path serves both states.
  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    err_next     = err_reg;
    sum_next     = sum_reg;
    above_next   = above_reg;
    out_err_next = out_err_reg;
    if (bus.clear) begin
      state_next = ST_ACCUM;
      acc_next   = '0;
      cnt_next   = '0;
      err_next   = 1'b0;
    end else if (accept) begin
      if (last) begin
        sum_next     = total;
        above_next   = (total >= SUM_W'(THRESH));
        out_err_next = err_reg | over;
        acc_next     = '0;
        cnt_next     = '0;
        err_next     = 1'b0;
        state_next   = ST_HOLD;
      end else begin
        acc_next   = total;
        cnt_next   = cnt_reg + CNT_W'(1);
        err_next   = err_reg | over;
        state_next = ST_ACCUM;
      end
    end else if (consume) begin
      state_next = ST_ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_ACCUM;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
      sum_reg     <= '0;
      above_reg   <= 1'b0;
      out_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      err_reg     <= err_next;
      sum_reg     <= sum_next;
      above_reg   <= above_next;
      out_err_reg <= out_err_next;
    end
  end

`ifdef POPACC_MAX_TRACK_EN
  logic [5:0] max_reg, max_next;
  logic [5:0] out_max_reg, out_max_next;
  logic [5:0] max_upd;

  assign max_upd     = (samp > max_reg) ? samp : max_reg;
  assign bus.out_max = out_max_reg;

  always_comb begin
    max_next     = max_reg;
    out_max_next = out_max_reg;
    if (bus.clear) begin
      max_next = '0;
    end else if (accept) begin
      if (last) begin
        out_max_next = max_upd;
        max_next     = '0;
      end else begin
        max_next = max_upd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_reg     <= '0;
      out_max_reg <= '0;
    end else begin
      max_reg     <= max_next;
      out_max_reg <= out_max_next;
    end
  end
`endif
endmodule

// File: tb/tb_popcount_window_accumulator.sv
// Directed and randomized checks of popcount_window_accumulator against a window-queue model.
// Build with POPACC_MAX_TRACK_EN defined to also check out_max.
module tb_popcount_window_accumulator;
  localparam int WINDOW = 8;
  localparam int SUM_W  = 9;
  localparam int THRESH = 128;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  popcount_window_accumulator_if #(.SUM_W(SUM_W)) bus ();

  popcount_window_accumulator #(
    .WINDOW(WINDOW), .SUM_W(SUM_W), .THRESH(THRESH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: the samples of the open window plus the held result, if any.
  int win[$];
  bit exp_valid;
  int exp_sum;
  bit exp_above;
  bit exp_err;
  int exp_max;

  task automatic model_reset();
    win.delete();
    exp_valid = 1'b0;
  endtask

  // Advance one clock, updating the model from the inputs present at that edge.
  task automatic step();
    bit acc_b;
    bit cons_b;
    if (bus.clear) begin
      model_reset();
    end else begin
      cons_b = exp_valid && bus.out_ready;
      acc_b  = bus.in_valid && (!exp_valid || bus.out_ready);
      if (cons_b) begin
        $display("[TB] result consumed sum=%0d above=%0b err=%0b", exp_sum, exp_above, exp_err);
        exp_valid = 1'b0;
      end
      if (acc_b) begin
        win.push_back(int'(bus.in_count));
        if (win.size() == WINDOW) begin
          exp_sum = 0;
          exp_err = 1'b0;
          exp_max = 0;
          foreach (win[k]) begin
            int v;
            v = (win[k] > 32) ? 32 : win[k];
            if (win[k] > 32) exp_err = 1'b1;
            if (v > exp_max) exp_max = v;
            exp_sum += v;
          end
          exp_above = (exp_sum >= THRESH);
          exp_valid = 1'b1;
          win.delete();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int val, input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_count = 6'(val);
      step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic async_reset_pulse();
    bus.in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
  endtask

  task automatic async_reset_release();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
    tests++; if (bus.out_sum !== 9'd0) begin fails++; $display("FAIL reset_out_sum got %0d want 0", bus.out_sum); end
    tests++; if (bus.out_above !== 1'b0) begin fails++; $display("FAIL reset_out_above got %0b want 0", bus.out_above); end
    tests++; if (bus.out_err !== 1'b0) begin fails++; $display("FAIL reset_out_err got %0b want 0", bus.out_err); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
    rst_n = 1'b1;
    model_reset();
    step();
  endtask

  task automatic test_basic_window();
    bus.out_ready = 1'b1;
    send(16, 8);
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %0b want 1", bus.out_valid); end
    tests++; if (bus.out_sum !== 9'd128) begin fails++; $display("FAIL basic_sum got %0d want 128", bus.out_sum); end
    tests++; if (bus.out_above !== 1'b1) begin fails++; $display("FAIL basic_above got %0b want 1", bus.out_above); end
    tests++; if (bus.out_err !== 1'b0) begin fails++; $display("FAIL basic_err got %0b want 0", bus.out_err); end
    step();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_drop got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_below_threshold();
    send(15, 8);
    tests++; if (bus.out_sum !== 9'd120) begin fails++; $display("FAIL below_sum got %0d want 120", bus.out_sum); end
    tests++; if (bus.out_above !== 1'b0) begin fails++; $display("FAIL below_above got %0b want 0", bus.out_above); end
    step();
    send(0, 8);
    tests++; if (bus.out_valid !== 1'b1 || bus.out_sum !== 9'd0) begin fails++; $display("FAIL zero_sum got valid=%0b sum=%0d want valid=1 sum=0", bus.out_valid, bus.out_sum); end
    step();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    send(4, 8);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_count = 6'd9;
      #1;
      tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cycle %0d got %0b want 0", i, bus.in_ready); end
      tests++; if (bus.out_valid !== 1'b1 || bus.out_sum !== 9'd32) begin fails++; $display("FAIL bp_hold cycle %0d got valid=%0b sum=%0d want valid=1 sum=32", i, bus.out_valid, bus.out_sum); end
      step();
    end
    bus.out_ready = 1'b1;
    bus.in_count  = 6'd5;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_pass_ready got %0b want 1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_consumed got valid %0b want 0", bus.out_valid); end
    send(1, 7);
    tests++; if (bus.out_valid !== 1'b1 || bus.out_sum !== 9'd12) begin fails++; $display("FAIL bp_next_sum got valid=%0b sum=%0d want valid=1 sum=12", bus.out_valid, bus.out_sum); end
    step();
  endtask

  task automatic test_clamp();
    bus.out_ready = 1'b1;
    send(40, 1);
    send(0, 7);
    tests++; if (bus.out_sum !== 9'd32 || bus.out_err !== 1'b1) begin fails++; $display("FAIL clamp got sum=%0d err=%0b want sum=32 err=1", bus.out_sum, bus.out_err); end
`ifdef POPACC_MAX_TRACK_EN
    tests++; if (bus.out_max !== 6'd32) begin fails++; $display("FAIL clamp_max got %0d want 32", bus.out_max); end
`endif
    step();
    send(3, 8);
    tests++; if (bus.out_sum !== 9'd24 || bus.out_err !== 1'b0) begin fails++; $display("FAIL clean_after_clamp got sum=%0d err=%0b want sum=24 err=0", bus.out_sum, bus.out_err); end
`ifdef POPACC_MAX_TRACK_EN
    tests++; if (bus.out_max !== 6'd3) begin fails++; $display("FAIL clean_max got %0d want 3", bus.out_max); end
`endif
    step();
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    send(10, 8);
    async_reset_pulse();
    tests++; if (bus.out_valid !== 1'b0 || bus.out_sum !== 9'd0) begin fails++; $display("FAIL areset_hold got valid=%0b sum=%0d want valid=0 sum=0", bus.out_valid, bus.out_sum); end
    async_reset_release();
    bus.out_ready = 1'b1;
    send(10, 3);
    async_reset_pulse();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL areset_partial got valid %0b want 0", bus.out_valid); end
    async_reset_release();
    send(1, 7);
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL areset_early_valid got %0b want 0", bus.out_valid); end
    send(1, 1);
    tests++; if (bus.out_valid !== 1'b1 || bus.out_sum !== 9'd8) begin fails++; $display("FAIL areset_sum got valid=%0b sum=%0d want valid=1 sum=8", bus.out_valid, bus.out_sum); end
    step();
  endtask

  task automatic test_clear();
    bus.out_ready = 1'b0;
    send(6, 8);
    bus.clear    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_count = 6'd7;
    step();
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL clear_valid got %0b want 0", bus.out_valid); end
    tests++; if (bus.out_sum !== 9'd48) begin fails++; $display("FAIL clear_keeps_sum got %0d want 48", bus.out_sum); end
    bus.out_ready = 1'b1;
    send(2, 8);
    tests++; if (bus.out_valid !== 1'b1 || bus.out_sum !== 9'd16) begin fails++; $display("FAIL clear_next_sum got valid=%0b sum=%0d want valid=1 sum=16", bus.out_valid, bus.out_sum); end
    step();
    send(5, 3);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    send(2, 8);
    tests++; if (bus.out_sum !== 9'd16) begin fails++; $display("FAIL clear_partial_sum got %0d want 16", bus.out_sum); end
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.in_count  = 6'($urandom_range(0, 40));
      bus.clear     = ($urandom_range(0, 59) == 0);
      #1;
      tests++; if (bus.in_ready !== (!exp_valid || bus.out_ready)) begin fails++; $display("FAIL rand_in_ready cycle %0d got %0b want %0b", c, bus.in_ready, !exp_valid || bus.out_ready); end
      tests++; if (bus.out_valid !== exp_valid) begin fails++; $display("FAIL rand_valid cycle %0d got %0b want %0b", c, bus.out_valid, exp_valid); end
      if (exp_valid) begin
        tests++; if (bus.out_sum !== SUM_W'(exp_sum) || bus.out_above !== exp_above || bus.out_err !== exp_err) begin
          fails++; $display("FAIL rand_result cycle %0d got sum=%0d above=%0b err=%0b want sum=%0d above=%0b err=%0b", c, bus.out_sum, bus.out_above, bus.out_err, exp_sum, exp_above, exp_err);
        end
`ifdef POPACC_MAX_TRACK_EN
        tests++; if (bus.out_max !== 6'(exp_max)) begin fails++; $display("FAIL rand_max cycle %0d got %0d want %0d", c, bus.out_max, exp_max); end
`endif
      end
      step();
    end
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_count  = 6'd0;
    bus.out_ready = 1'b1;
    model_reset();
    exp_sum = 0; exp_above = 1'b0; exp_err = 1'b0; exp_max = 0;
    test_reset();
    test_basic_window();
    test_below_threshold();
    test_backpressure();
    test_clamp();
    test_async_reset();
    test_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/popcount_window_accumulator.md
Name: popcount_window_accumulator

Overview:
Sequential stage directly downstream of the 32-input population counter. Each accepted sample is that counter's 6-bit ones-count (0..32). The block sums WINDOW consecutive samples, compares the sum against a threshold, and presents the result on a valid/ready output port. It is the first clocked stage after the combinational popcount tree and registers its result for the next consumer.

Parameters:
WINDOW, 8, samples per window; legal 1..256.
SUM_W, 9, width of the window sum; must be >= clog2(32*WINDOW+1).
THRESH, 128, out_above asserts when sum >= THRESH; THRESH < 2**SUM_W.

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous abandon of the partial window and the held result
in_valid  in  1  in_count is valid this cycle
in_ready  out  1  block accepts in_count this cycle
in_count  in  6  popcount sample; legal 0..32
out_valid  out  1  window result is held on the out_* ports
out_ready  in  1  consumer takes the result this cycle
out_sum  out  SUM_W  sum of the WINDOW samples
out_above  out  1  out_sum >= THRESH
out_err  out  1  some sample in the window was >32 and was clamped

Behaviour:
- Reset (rst_n=0, async): state=ACCUM, accumulator=0, sample counter=0, err=0; out_valid=0, out_sum=0, out_above=0, out_err=0. Ready for input on the first edge after release.
- Accept rule: a sample is taken when in_valid && in_ready. Output is consumed when out_valid && out_ready.
- Clamp: a sample above 32 is added as 32 and sets the window err flag. The flag is sticky until the window completes.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - On accept: acc += sample, cnt++.
  - On accepting sample number WINDOW (cnt==WINDOW-1): out_sum <= acc+sample, out_above/out_err registered, acc and cnt cleared, go to HOLD.
- Latency: out_valid rises on the edge after the final sample is accepted.
- WINDOW=1: every accepted sample produces a result.
- State HOLD:
  - out_valid=1; out_* stay stable until consumed.
  - in_ready = out_ready (combinational pass-through). A sample offered in the same cycle the output is consumed is accepted and becomes sample 1 of the next window.
  - On consume: if WINDOW==1 and a sample is accepted in the same cycle, stay in HOLD with the new result. Otherwise go to ACCUM, or, if a sample was accepted, go to ACCUM with acc=sample and cnt=1.
  - With out_ready=0: in_ready=0 and no sample is lost.
- Arithmetic: accumulator is SUM_W bits unsigned; the parameter rule guarantees no overflow. Comparison is unsigned.
- clear=1 (sync, highest priority after reset): acc, cnt and err are zeroed, state goes to ACCUM, out_valid=0 on the next edge. A held result is discarded and a sample offered in that cycle is dropped. out_sum, out_above and out_err keep their last values but are invalid.
- Reset mid-window: the partial sum is discarded and the next window needs a full WINDOW samples.

Optional Feature:
Macro POPACC_MAX_TRACK_EN.
- Defined: adds output out_max (6 bits), the largest clamped sample in the window. It is registered with out_sum, reset to 0, and its running value is zeroed by clear.
- Undefined: the port and its logic are absent; all other behaviour is unchanged.

Test Plan:
- Defaults, out_ready=1, eight samples of 16 on back-to-back cycles -> out_valid=1 for one cycle, one edge after the 8th sample; out_sum=128, out_above=1, out_err=0.
- Eight samples of 15 -> out_sum=120, out_above=0; a further eight samples of 0 -> out_sum=0.
- Complete a window of eight 4s with out_ready=0 for 5 cycles -> in_ready=0, out_sum stays 32. Then out_ready=1 with in_count=5 in the same cycle -> result consumed and 5 accepted; the next window of 5 plus seven 1s gives out_sum=12.
- Samples 40,0,0,0,0,0,0,0 -> out_sum=32, out_err=1; the next clean window gives out_err=0. With POPACC_MAX_TRACK_EN defined, out_max=32.
- Three samples of 10, assert rst_n=0 asynchronously mid-cycle -> out_valid=0 immediately. After release, eight samples of 1 -> out_sum=8.
- Hold a result with out_ready=0, pulse clear with in_valid=1 and count 7 -> out_valid=0 next edge and 7 not counted; the next eight samples of 2 give out_sum=16.
